trap_ctrl: RTL and testbench

- Parametrised machine-mode trap controller for the rv32ima core. Successor to the fixed six-flag exception bundle.
- Accepts a vector of synchronous exception flags and a vector of interrupt lines, arbitrates by priority and owns the trap CSRs (mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause, mtval).
- Sequences pipeline flush and redirect with a flush handshake, and handles mret.
- Sits beside the execute stage; its redirect outputs feed the fetch stage.

---
 rtl/trap_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: exception/interrupt arbitration, trap CSRs, flush/redirect, mret.
// Define TRAP_VECTORED_EN to enable vectored interrupt dispatch via mtvec[1:0]=01.
module trap_ctrl #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_EXC  = 16,
   parameter int unsigned NUM_IRQ  = 16,
   parameter int unsigned IRQ_SYNC = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_EXC-1:0] exc_flags,
   input  logic               exc_valid,
   input  logic [XLEN-1:0]    exc_pc,
   input  logic [XLEN-1:0]    exc_tval,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [XLEN-1:0]    irq_pc,
   input  logic               mret,
   input  logic               csr_we,
   input  logic [11:0]        csr_addr,
   input  logic [XLEN-1:0]    csr_wdata,
   output logic [XLEN-1:0]    csr_rdata,
   output logic               flush_req,
   input  logic               flush_ack,
   output logic               redirect,
   output logic [XLEN-1:0]    redirect_pc,
   output logic               busy
);

   localparam int unsigned EXC_W = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
   localparam int unsigned IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   localparam logic [11:0] AddrMstatus = 12'h300;
   localparam logic [11:0] AddrMie     = 12'h304;
   localparam logic [11:0] AddrMtvec   = 12'h305;
   localparam logic [11:0] AddrMepc    = 12'h341;
   localparam logic [11:0] AddrMcause  = 12'h342;
   localparam logic [11:0] AddrMtval   = 12'h343;
   localparam logic [11:0] AddrMip     = 12'h344;

   typedef enum logic [1:0] {StIdle, StFlush, StRedirect, StRet} state_t;

   state_t state_q, state_d;

   logic               mstatus_mie_q, mstatus_mie_d;
   logic               mstatus_mpie_q, mstatus_mpie_d;
   logic [NUM_IRQ-1:0] mie_q, mie_d;
   logic [XLEN-1:0]    mtvec_q, mtvec_d;
   logic [XLEN-1:0]    mepc_q, mepc_d;
   logic [XLEN-1:0]    mcause_q, mcause_d;
   logic [XLEN-1:0]    mtval_q, mtval_d;

   logic [NUM_IRQ-1:0] irq_s;
   logic [NUM_IRQ-1:0] pending;
   logic [EXC_W-1:0]   exc_code;
   logic [IRQ_W-1:0]   irq_code;
   logic               exc_present;
   logic               exc_take;
   logic               irq_take;
   logic               mret_take;
   logic [XLEN-1:0]    mepc_rd;
   logic [XLEN-1:0]    trap_target;

   generate
      if (IRQ_SYNC != 0) begin : g_sync
         logic [NUM_IRQ-1:0] sync1_q, sync2_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               sync1_q <= '0;
               sync2_q <= '0;
            end else begin
               sync1_q <= irq;
               sync2_q <= sync1_q;
            end
         end
         assign irq_s = sync2_q;
      end else begin : g_nosync
         assign irq_s = irq;
      end
   endgenerate

   assign pending = irq_s & mie_q & {NUM_IRQ{mstatus_mie_q}};

   // Downward scan leaves the lowest set index as the winner.
   always_comb begin
      exc_code = '0;
      for (int k = int'(NUM_EXC) - 1; k >= 0; k--) begin
         if (exc_flags[EXC_W'(k)]) exc_code = EXC_W'(k);
      end
   end

   always_comb begin
      irq_code = '0;
      for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
         if (pending[IRQ_W'(k)]) irq_code = IRQ_W'(k);
      end
   end

   assign exc_present = exc_valid && (|exc_flags);
   assign exc_take    = (state_q == StIdle) && exc_present;
   assign irq_take    = (state_q == StIdle) && !exc_present && (|pending);
   assign mret_take   = (state_q == StIdle) && mret && !exc_present && !(|pending);

   assign mepc_rd = {mepc_q[XLEN-1:2], 2'b00};

   always_comb begin
      trap_target = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
      if ((mtvec_q[1:0] == 2'b01) && mcause_q[XLEN-1]) begin
         trap_target = {mtvec_q[XLEN-1:2], 2'b00} + (XLEN'(mcause_q[IRQ_W-1:0]) << 2);
      end
`endif
   end

   // FSM next state and outputs.
   always_comb begin
      state_d     = state_q;
      flush_req   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      unique case (state_q)
         StIdle: begin
            if (exc_take || irq_take) state_d = StFlush;
            else if (mret_take)       state_d = StRet;
         end
         StFlush: begin
            flush_req = 1'b1;
            if (flush_ack) state_d = StRedirect;
         end
         StRedirect: begin
            redirect    = 1'b1;
            redirect_pc = trap_target;
            state_d     = StIdle;
         end
         StRet: begin
            redirect    = 1'b1;
            redirect_pc = mepc_rd;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy = (state_q != StIdle);

   // CSR writes first; trap and mret updates then override the fields they own.
   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_d          = mie_q;
      mtvec_d        = mtvec_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;

      if (csr_we) begin
         unique case (csr_addr)
            AddrMstatus: begin
               mstatus_mie_d  = csr_wdata[3];
               mstatus_mpie_d = csr_wdata[7];
            end
            AddrMie: mie_d = csr_wdata[NUM_IRQ-1:0];
            AddrMtvec: begin
`ifdef TRAP_VECTORED_EN
               mtvec_d = {csr_wdata[XLEN-1:2], (csr_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
               mtvec_d = {csr_wdata[XLEN-1:2], 2'b00};
`endif
            end
            AddrMepc:   mepc_d   = csr_wdata;
            AddrMcause: mcause_d = csr_wdata;
            AddrMtval:  mtval_d  = csr_wdata;
            default: ;
         endcase
      end

      if (exc_take) begin
         mcause_d       = XLEN'(exc_code);
         mepc_d         = exc_pc;
         mtval_d        = exc_tval;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (irq_take) begin
         mcause_d       = {1'b1, (XLEN-1)'(irq_code)};
         mepc_d         = irq_pc;
         mtval_d        = '0;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret_take) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mtvec_q        <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
      end else begin
         state_q        <= state_d;
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mtvec_q        <= mtvec_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
      end
   end

   always_comb begin
      csr_rdata = '0;
      unique case (csr_addr)
         AddrMstatus: csr_rdata = XLEN'({mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000});
         AddrMie:     csr_rdata = XLEN'(mie_q);
         AddrMip:     csr_rdata = XLEN'(irq_s);
         AddrMtvec:   csr_rdata = mtvec_q;
         AddrMepc:    csr_rdata = mepc_rd;
         AddrMcause:  csr_rdata = mcause_q;
         AddrMtval:   csr_rdata = mtval_q;
         default:     csr_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected redirects are queued at stimulus time and
// checked by a negedge monitor; CSR state is checked directly with hand-computed values.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] exc_flags = '0;
   logic        exc_valid = 1'b0;
   logic [31:0] exc_pc = '0;
   logic [31:0] exc_tval = '0;
   logic [15:0] irq = '0;
   logic [31:0] irq_pc = '0;
   logic        mret = 1'b0;
   logic        csr_we = 1'b0;
   logic [11:0] csr_addr = '0;
   logic [31:0] csr_wdata = '0;
   logic [31:0] csr_rdata;
   logic        flush_req;
   logic        flush_ack = 1'b0;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        busy;

   trap_ctrl #(
      .XLEN     (32),
      .NUM_EXC  (16),
      .NUM_IRQ  (16),
      .IRQ_SYNC (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .exc_flags   (exc_flags),
      .exc_valid   (exc_valid),
      .exc_pc      (exc_pc),
      .exc_tval    (exc_tval),
      .irq         (irq),
      .irq_pc      (irq_pc),
      .mret        (mret),
      .csr_we      (csr_we),
      .csr_addr    (csr_addr),
      .csr_wdata   (csr_wdata),
      .csr_rdata   (csr_rdata),
      .flush_req   (flush_req),
      .flush_ack   (flush_ack),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] pc;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;

`ifdef TRAP_VECTORED_EN
   localparam logic [31:0] VecIrqPc  = 32'h20C;
   localparam logic [31:0] Mtvec101  = 32'h101;
`else
   localparam logic [31:0] VecIrqPc  = 32'h200;
   localparam logic [31:0] Mtvec101  = 32'h100;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
      csr_addr = a;
      #1;
      chk(name, csr_rdata, exp);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csr_we    = 1'b1;
      csr_addr  = a;
      csr_wdata = d;
      tick();
      csr_we    = 1'b0;
   endtask

   // dc: cycles from the current (detection) cycle to the expected redirect pulse.
   task automatic expect_redirect(input logic [31:0] pc, input int dc);
      sb.push_back('{pc, cyc + dc});
   endtask

   always @(negedge clk) begin
      if (redirect) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_redirect: got pc %h at cycle %0d expected none",
                     redirect_pc, cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("redirect_pc", redirect_pc, mon_e.pc);
            chk("redirect_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) tick();
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_flush_req", {31'b0, flush_req}, 32'h0);
      chk("rst_redirect", {31'b0, redirect}, 32'h0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
      rst = 1'b0;
      tick();
      rd(12'h300, 32'h0, "rst_mstatus");
      rd(12'h304, 32'h0, "rst_mie");
      rd(12'h305, 32'h0, "rst_mtvec");
      rd(12'h341, 32'h0, "rst_mepc");
      tick();
      rd(12'h342, 32'h0, "rst_mcause");
      rd(12'h343, 32'h0, "rst_mtval");
      rd(12'h344, 32'h0, "rst_mip");
      rd(12'h123, 32'h0, "unmapped");
      tick();

      // Exception redirect, flush_ack one cycle after flush_req
      wr(12'h305, 32'h100);
      wr(12'h300, 32'h8);
      exc_valid = 1'b1; exc_flags = 16'h0004; exc_pc = 32'h2000; exc_tval = 32'hDEAD;
      expect_redirect(32'h100, 3);
      tick();
      exc_valid = 1'b0; exc_flags = '0;
      chk("t1_flush_req", {31'b0, flush_req}, 32'h1);
      chk("t1_busy", {31'b0, busy}, 32'h1);
      tick();
      flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      tick();
      rd(12'h342, 32'h2, "t1_mcause");
      rd(12'h341, 32'h2000, "t1_mepc");
      rd(12'h343, 32'hDEAD, "t1_mtval");
      rd(12'h300, 32'h80, "t1_mstatus");
      tick();

      // Exception beats a pending enabled interrupt; ack in first FLUSH cycle
      wr(12'h304, 32'h80);
      irq = 16'h0080;
      repeat (3) tick();
      rd(12'h344, 32'h80, "t2_mip");
      wr(12'h300, 32'h88);
      exc_valid = 1'b1; exc_flags = 16'h0848; exc_pc = 32'h2100; exc_tval = 32'h1234;
      expect_redirect(32'h100, 2);
      tick();
      exc_valid = 1'b0; exc_flags = '0;
      flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      tick();
      rd(12'h342, 32'h3, "t2_mcause");
      rd(12'h341, 32'h2100, "t2_mepc");
      rd(12'h343, 32'h1234, "t2_mtval");
      rd(12'h300, 32'h80, "t2_mstatus");
      repeat (5) tick();
      chk("t2_irq_blocked", {31'b0, busy}, 32'h0);
      irq = '0;
      repeat (3) tick();

      // Interrupt through the synchroniser
      wr(12'h300, 32'h8);
      irq_pc = 32'h3004;
      flush_ack = 1'b1;
      irq = 16'h0080;
      expect_redirect(32'h100, 4);
      tick();
      tick();
      chk("t3_detect_idle", {31'b0, busy}, 32'h0);
      tick();
      irq = '0;
      chk("t3_flush_req", {31'b0, flush_req}, 32'h1);
      tick();
      tick();
      flush_ack = 1'b0;
      rd(12'h342, 32'h80000007, "t3_mcause");
      rd(12'h341, 32'h3004, "t3_mepc");
      rd(12'h343, 32'h0, "t3_mtval");
      rd(12'h300, 32'h80, "t3_mstatus");
      tick();

      // mret returns to mepc and restores MIE
      mret = 1'b1;
      expect_redirect(32'h3004, 1);
      tick();
      mret = 1'b0;
      tick();
      rd(12'h300, 32'h88, "t4_mstatus");
      tick();

      // Exception + mret + CSR write to mtval in one cycle: exception wins
      flush_ack = 1'b1;
      exc_valid = 1'b1; exc_flags = 16'h0100; exc_pc = 32'h2200; exc_tval = 32'h77;
      mret = 1'b1;
      csr_we = 1'b1; csr_addr = 12'h343; csr_wdata = 32'hFFFF;
      expect_redirect(32'h100, 2);
      tick();
      exc_valid = 1'b0; exc_flags = '0; mret = 1'b0; csr_we = 1'b0;
      tick();
      tick();
      flush_ack = 1'b0;
      rd(12'h342, 32'h8, "t5_mcause");
      rd(12'h343, 32'h77, "t5_mtval");
      rd(12'h341, 32'h2200, "t5_mepc");
      rd(12'h300, 32'h80, "t5_mstatus");
      tick();

      // CSR width rules
      wr(12'h341, 32'h1237);
      rd(12'h341, 32'h1234, "mepc_low_bits");
      wr(12'h304, 32'hFFFFFFFF);
      rd(12'h304, 32'h0000FFFF, "mie_width");
      wr(12'h305, 32'h203);
      rd(12'h305, 32'h200, "mtvec_mode_1x");
      wr(12'h305, 32'h101);
      rd(12'h305, Mtvec101, "mtvec_mode_01");
      wr(12'h305, 32'h100);

      // Flush stall followed by reset mid-sequence
      exc_valid = 1'b1; exc_flags = 16'h0001; exc_pc = 32'h4000; exc_tval = 32'h0;
      tick();
      exc_valid = 1'b0; exc_flags = '0;
      for (int i = 0; i < 4; i++) begin
         chk("t6_flush_hold", {31'b0, flush_req}, 32'h1);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_busy", {31'b0, busy}, 32'h0);
      chk("t6_flush_req", {31'b0, flush_req}, 32'h0);
      rd(12'h300, 32'h0, "t6_mstatus");
      rd(12'h304, 32'h0, "t6_mie");
      rd(12'h305, 32'h0, "t6_mtvec");
      rd(12'h341, 32'h0, "t6_mepc");
      tick();
      rd(12'h342, 32'h0, "t6_mcause");
      rd(12'h343, 32'h0, "t6_mtval");
      repeat (5) tick();
      chk("t6_idle", {31'b0, busy}, 32'h0);

      // Vectored dispatch (base address when the feature is compiled out)
      wr(12'h305, 32'h201);
      wr(12'h304, 32'h8);
      wr(12'h300, 32'h8);
      flush_ack = 1'b1;
      irq = 16'h0008;
      expect_redirect(VecIrqPc, 4);
      repeat (3) tick();
      irq = '0;
      tick();
      tick();
      exc_valid = 1'b1; exc_flags = 16'h0002; exc_pc = 32'h5000; exc_tval = 32'h0;
      expect_redirect(32'h200, 2);
      tick();
      exc_valid = 1'b0; exc_flags = '0;
      tick();
      tick();
      flush_ack = 1'b0;
      rd(12'h342, 32'h1, "t7_mcause");

      repeat (3) tick();
      chk("sb_empty", sb.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
